pwm_capture: RTL and testbench
==============================

// Module: pwm_capture
// PURPOSE
//  Measures an incoming PWM waveform on one clock domain: high time and period per cycle, for a requested number of periods.
//  Receive-side counterpart of the team's PWM generator; used on the bench and in loopback to check generated PWM.
//  Reports each measured period with a one-cycle valid strobe.
//  Flags done after i_times periods, or timeout if edges stop arriving.
// PARAMETERS
//  CNT_W        32     width of period/high counters and outputs (units: i_clk cycles)
//  TIMEOUT_CYC  1000000 max cycles without a qualifying edge before abort
//  DGL_CYC      4      stable-sample count for deglitch filter (used only with PWM_DEGLITCH_EN)
// PORTS
//  i_clk       in   1       system clock (50MHz)
//  i_rst       in   1       reset
//  i_en        in   1       start request; rising edge arms a measurement run
//  i_times     in   16      number of periods to measure per run (0 treated as 1)
//  i_pwm       in   1       PWM input, asynchronous to i_clk
//  o_valid     out  1       1-cycle strobe: o_period/o_high/o_idx hold a new result
//  o_period    out  CNT_W   cycles between two consecutive rising edges
//  o_high      out  CNT_W   cycles from rising edge to following falling edge
//  o_idx       out  16      index of reported period, 0..i_times-1
//  o_done      out  1       1-cycle strobe after the last period of a run
//  o_timeout   out  1       1-cycle strobe: run aborted, no edge within TIMEOUT_CYC
//  o_busy      out  1       high while a run is in progress
// BEHAVIOUR
//  Clock i_clk; reset synchronous, active-high (i_rst); takes priority over every other input.
//  Reset: state IDLE, all counters 0, all outputs 0 (o_valid, o_period, o_high, o_idx, o_done, o_timeout, o_busy).
//  i_pwm passes a 2-FF synchronizer, then a third register for edge detect: rise = s2&~s3, fall = ~s2&s3.
//  i_en is registered; start = rising edge of i_en. i_times is latched at start.
//  FSM:
//   IDLE   : o_busy=0. start -> ARM.
//   ARM    : wait first rise (discard partial period). rise -> MEAS; pcnt<=1, hcnt<=1.
//   MEAS   : pcnt++ each cycle; hcnt++ while high-phase flag set.
//            fall clears high-phase flag and freezes hcnt.
//            rise -> o_valid=1, o_period=pcnt, o_high=hcnt, o_idx=tcnt.
//              If tcnt==times-1, o_done=1 in the same cycle and go IDLE.
//              Otherwise tcnt++, pcnt<=1, hcnt<=1, stay in MEAS.
//  Latency: o_valid is asserted 4 i_clk edges after the first edge that samples the closing i_pwm rise.
//   This is 2 sync + 1 edge + 1 output register.
//  Counters saturate at 2^CNT_W-1; no wrap. A saturated period is still reported at the next rise.
//  Timeout counter: cleared on every rise/fall and on start; counts in ARM and MEAS.
//   At TIMEOUT_CYC: o_timeout=1 for one cycle, go IDLE, no o_valid.
//   Covers 0% and 100% duty inputs.
//  o_period/o_high/o_idx hold their last values until the next o_valid; strobes are otherwise 0.
//  Simultaneous start while busy: ignored (i_en rise only honoured in IDLE).
//  Fall in ARM is ignored. Rise and timeout in the same cycle: rise wins, timeout counter clears.
//  i_rst mid-run: abort immediately, no o_done/o_timeout strobe, outputs to reset values.
// CONFIGURATION
//  PWM_DEGLITCH_EN defined:
//   after the synchronizer, the filtered level changes only after DGL_CYC consecutive equal samples.
//   Pulses shorter than DGL_CYC cycles are ignored.
//   Latency grows by DGL_CYC cycles. Measured widths are unchanged for clean input (both edges delayed equally).
//  PWM_DEGLITCH_EN undefined:
//   no filter; every synchronized transition is an edge. Latency as above.
// TESTING
//  1. PWM period 10, high 3; start with i_times=4.
//     -> 4 o_valid with period=10, high=3, idx 0..3; o_done coincident with idx=3; o_busy drops next cycle.
//  2. Start mid-high-phase of period 20/high 7 input.
//     -> first partial period discarded; first report period=20, high=7, idx=0.
//  3. i_pwm held 0 (then held 1) with TIMEOUT_CYC=50.
//     -> o_timeout exactly 50 cycles after last edge/start; no o_valid; FSM IDLE.
//  4. i_rst asserted 1 cycle during idx=1 of an i_times=5 run.
//     -> all outputs 0 next cycle; no o_done; new i_en rise restarts from idx=0.
//  5. With PWM_DEGLITCH_EN, DGL_CYC=4: 2-cycle glitches injected in period 40/high 15.
//     -> reports period=40, high=15. Without macro: extra short periods reported.
//  6. i_times=0, then i_en toggled while busy.
//     -> exactly one o_valid + o_done; the second i_en rise during the run is ignored.

Source files
------------

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an asynchronous PWM input
// for a requested number of periods, with done and timeout reporting.
// Optional input deglitch filter is enabled by defining PWM_DEGLITCH_EN.
module pwm_capture #(
  parameter int CNT_W       = 32,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int DGL_CYC     = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic [15:0]       i_times,
  input  logic              i_pwm,
  output logic              o_valid,
  output logic [CNT_W-1:0]  o_period,
  output logic [CNT_W-1:0]  o_high,
  output logic [15:0]       o_idx,
  output logic              o_done,
  output logic              o_timeout,
  output logic              o_busy
);

  localparam int              TO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

`ifdef PWM_DEGLITCH_EN
  localparam bit DGL_ON = 1'b1;
`else
  localparam bit DGL_ON = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

  logic s1, s2, s3, lvl;
  logic rise_q, fall_q;
  logic en_q1, en_q2;
  logic start;

  state_t            state, state_n;
  logic [CNT_W-1:0]  pcnt, pcnt_n;
  logic [CNT_W-1:0]  hcnt, hcnt_n;
  logic              high_ph, high_ph_n;
  logic [15:0]       tcnt, tcnt_n;
  logic [15:0]       times_q, times_n;
  logic [TO_W-1:0]   tocnt, tocnt_n;
  logic              valid_n, done_n, tmo_n, busy_n;
  logic [CNT_W-1:0]  period_n, high_out_n;
  logic [15:0]       idx_n;

  // Counters stick at all-ones instead of wrapping so long periods stay visible
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // Two-flop synchronizer bringing the asynchronous PWM into the clock domain
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= i_pwm;
      s2 <= s1;
    end
  end

  generate
    if (DGL_ON && DGL_CYC > 0) begin : g_dgl
      localparam int            DW     = $clog2(DGL_CYC + 1);
      localparam logic [DW-1:0] D_LAST = DW'(DGL_CYC - 1);
      logic          filt;
      logic [DW-1:0] dcnt;

      // Filtered level flips only after DGL_CYC consecutive samples disagree with it
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          filt <= 1'b0;
          dcnt <= '0;
        end else if (s2 == filt) begin
          dcnt <= '0;
        end else if (dcnt == D_LAST) begin
          filt <= s2;
          dcnt <= '0;
        end else begin
          dcnt <= dcnt + 1'b1;
        end
      end

      assign lvl = filt;
    end else begin : g_nodgl
      assign lvl = s2;
    end
  endgenerate

  // Edge detect on the clean level, registered so the FSM sees one-cycle edge pulses
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s3     <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      en_q1  <= 1'b0;
      en_q2  <= 1'b0;
    end else begin
      s3     <= lvl;
      rise_q <= lvl & ~s3;
      fall_q <= ~lvl & s3;
      en_q1  <= i_en;
      en_q2  <= en_q1;
    end
  end

  assign start = en_q1 & ~en_q2;

  // State, measurement counters and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      pcnt      <= '0;
      hcnt      <= '0;
      high_ph   <= 1'b0;
      tcnt      <= '0;
      times_q   <= '0;
      tocnt     <= '0;
      o_valid   <= 1'b0;
      o_period  <= '0;
      o_high    <= '0;
      o_idx     <= '0;
      o_done    <= 1'b0;
      o_timeout <= 1'b0;
      o_busy    <= 1'b0;
    end else begin
      state     <= state_n;
      pcnt      <= pcnt_n;
      hcnt      <= hcnt_n;
      high_ph   <= high_ph_n;
      tcnt      <= tcnt_n;
      times_q   <= times_n;
      tocnt     <= tocnt_n;
      o_valid   <= valid_n;
      o_period  <= period_n;
      o_high    <= high_out_n;
      o_idx     <= idx_n;
      o_done    <= done_n;
      o_timeout <= tmo_n;
      o_busy    <= busy_n;
    end
  end

  // Next-state logic: arm on start, skip the partial first period, report on each closing rise
  always_comb begin
    state_n    = state;
    pcnt_n     = pcnt;
    hcnt_n     = hcnt;
    high_ph_n  = high_ph;
    tcnt_n     = tcnt;
    times_n    = times_q;
    tocnt_n    = tocnt;
    valid_n    = 1'b0;
    done_n     = 1'b0;
    tmo_n      = 1'b0;
    period_n   = o_period;
    high_out_n = o_high;
    idx_n      = o_idx;

    case (state)
      IDLE: begin
        if (start) begin
          state_n = ARM;
          times_n = (i_times == 16'd0) ? 16'd1 : i_times;
          tcnt_n  = '0;
          tocnt_n = '0;
        end
      end

      ARM: begin
        if (rise_q) begin
          state_n   = MEAS;
          pcnt_n    = CNT_ONE;
          hcnt_n    = CNT_ONE;
          high_ph_n = 1'b1;
          tocnt_n   = '0;
        end else if (fall_q) begin
          tocnt_n = '0;
        end else if (tocnt == TO_LAST) begin
          tmo_n   = 1'b1;
          state_n = IDLE;
        end else begin
          tocnt_n = tocnt + 1'b1;
        end
      end

      MEAS: begin
        if (rise_q) begin
          valid_n    = 1'b1;
          period_n   = pcnt;
          high_out_n = hcnt;
          idx_n      = tcnt;
          tocnt_n    = '0;
          if (tcnt == times_q - 16'd1) begin
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            tcnt_n    = tcnt + 16'd1;
            pcnt_n    = CNT_ONE;
            hcnt_n    = CNT_ONE;
            high_ph_n = 1'b1;
          end
        end else begin
          pcnt_n = sat_inc(pcnt);
          if (fall_q) begin
            high_ph_n = 1'b0;
            tocnt_n   = '0;
          end else begin
            if (high_ph) begin
              hcnt_n = sat_inc(hcnt);
            end
            if (tocnt == TO_LAST) begin
              tmo_n   = 1'b1;
              state_n = IDLE;
            end else begin
              tocnt_n = tocnt + 1'b1;
            end
          end
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE) | done_n | tmo_n;
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed self-checking bench for pwm_capture.
// Builds with or without PWM_DEGLITCH_EN; glitch and latency expectations follow the macro.
module tb_pwm_capture;

  localparam int CNT_W  = 16;
  localparam int TO_CYC = 50;
  localparam int DGL    = 4;

`ifdef PWM_DEGLITCH_EN
  localparam int LAT_EXTRA = DGL;
  localparam bit DGL_BUILD = 1'b1;
`else
  localparam int LAT_EXTRA = 0;
  localparam bit DGL_BUILD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             i_rst;
  logic             i_en;
  logic [15:0]      i_times;
  logic             i_pwm;
  logic             o_valid;
  logic [CNT_W-1:0] o_period;
  logic [CNT_W-1:0] o_high;
  logic [15:0]      o_idx;
  logic             o_done;
  logic             o_timeout;
  logic             o_busy;

  int n_cmp = 0;
  int n_bad = 0;

  // PWM generator controls
  bit gen_on   = 1'b0;
  bit hold_lvl = 1'b0;
  int gen_per  = 10;
  int gen_hi   = 3;
  int gl_at    = 0;
  int gl_len   = 0;
  int ph       = 0;

  // Monitor records
  int q_per[$];
  int q_hi[$];
  int q_idx[$];
  int n_done   = 0;
  int n_to     = 0;
  int done_idx = 0;
  bit done_vld = 1'b0;

  pwm_capture #(
    .CNT_W       (CNT_W),
    .TIMEOUT_CYC (TO_CYC),
    .DGL_CYC     (DGL)
  ) dut (
    .i_clk     (clk),
    .i_rst     (i_rst),
    .i_en      (i_en),
    .i_times   (i_times),
    .i_pwm     (i_pwm),
    .o_valid   (o_valid),
    .o_period  (o_period),
    .o_high    (o_high),
    .o_idx     (o_idx),
    .o_done    (o_done),
    .o_timeout (o_timeout),
    .o_busy    (o_busy)
  );

  always #10 clk = ~clk;

  // PWM source: changes shortly after a rising edge, like an unrelated clock domain
  initial begin : pwm_gen
    i_pwm = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (gen_on) begin
        i_pwm = ((ph < gen_hi) != (ph >= gl_at && ph < gl_at + gl_len));
        ph    = (ph + 1 >= gen_per) ? 0 : ph + 1;
      end else begin
        i_pwm = hold_lvl;
        ph    = 0;
      end
    end
  end

  // Collect every report and strobe at the falling edge
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (o_valid) begin
        q_per.push_back(int'(o_period));
        q_hi.push_back(int'(o_high));
        q_idx.push_back(int'(o_idx));
      end
      if (o_done) begin
        n_done++;
        done_idx = int'(o_idx);
        done_vld = o_valid;
      end
      if (o_timeout) n_to++;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_pwm(input int per, input int hi, input int at, input int len);
    gen_on = 1'b0;
    tick();
    tick();
    gen_per = per;
    gen_hi  = hi;
    gl_at   = at;
    gl_len  = len;
    gen_on  = 1'b1;
  endtask

  task automatic start_run(input int times);
    i_times = 16'(times);
    i_en    = 1'b1;
    tick();
    tick();
    i_en = 1'b0;
  endtask

  task automatic wait_done(input int dbase, input int bound, input string name);
    int k;
    k = 0;
    while (n_done == dbase && k < bound) begin
      tick();
      k++;
    end
    if (n_done == dbase) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL %s_wait: no o_done within %0d cycles", name, bound);
    end
  endtask

  task automatic test_reset();
    i_rst   = 1'b1;
    i_en    = 1'b0;
    i_times = 16'd0;
    repeat (3) tick();
    n_cmp++;
    if ({o_valid, o_done, o_timeout, o_busy} !== 4'b0000) begin
      n_bad++;
      $display("[TB] FAIL reset_strobes: got %b want 0000", {o_valid, o_done, o_timeout, o_busy});
    end
    n_cmp++;
    if (o_period !== '0) begin n_bad++; $display("[TB] FAIL reset_period: got %0d want 0", o_period); end
    n_cmp++;
    if (o_high !== '0) begin n_bad++; $display("[TB] FAIL reset_high: got %0d want 0", o_high); end
    n_cmp++;
    if (o_idx !== '0) begin n_bad++; $display("[TB] FAIL reset_idx: got %0d want 0", o_idx); end
    i_rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int vbase, dbase;
    set_pwm(10, 3, 0, 0);
    repeat (5) tick();
    vbase = q_per.size();
    dbase = n_done;
    start_run(4);
    wait_done(dbase, 200, "basic");
    n_cmp++;
    if (o_busy !== 1'b1) begin n_bad++; $display("[TB] FAIL basic_busy_at_done: got %b want 1", o_busy); end
    n_cmp++;
    if (done_vld !== 1'b1 || done_idx != 3) begin
      n_bad++;
      $display("[TB] FAIL basic_done_with_idx3: got valid=%b idx=%0d want valid=1 idx=3", done_vld, done_idx);
    end
    tick();
    n_cmp++;
    if (o_busy !== 1'b0) begin n_bad++; $display("[TB] FAIL basic_busy_drop: got %b want 0", o_busy); end
    repeat (3) tick();
    n_cmp++;
    if (o_valid !== 1'b0 || o_period !== 16'd10) begin
      n_bad++;
      $display("[TB] FAIL basic_hold: got valid=%b period=%0d want valid=0 period=10", o_valid, o_period);
    end
    n_cmp++;
    if (q_per.size() != vbase + 4) begin
      n_bad++;
      $display("[TB] FAIL basic_count: got %0d reports want 4", q_per.size() - vbase);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (q_per[vbase+i] != 10 || q_hi[vbase+i] != 3 || q_idx[vbase+i] != i) begin
          n_bad++;
          $display("[TB] FAIL basic_report%0d: got per=%0d hi=%0d idx=%0d want per=10 hi=3 idx=%0d",
                   i, q_per[vbase+i], q_hi[vbase+i], q_idx[vbase+i], i);
        end
      end
    end
  endtask

  task automatic test_midhigh();
    int vbase, dbase, k;
    set_pwm(20, 7, 0, 0);
    k = 0;
    while (ph != 5 && k < 100) begin
      tick();
      k++;
    end
    vbase = q_per.size();
    dbase = n_done;
    start_run(1);
    wait_done(dbase, 200, "midhigh");
    n_cmp++;
    if (q_per.size() != vbase + 1) begin
      n_bad++;
      $display("[TB] FAIL midhigh_count: got %0d reports want 1", q_per.size() - vbase);
    end else begin
      n_cmp++;
      if (q_per[vbase] != 20 || q_hi[vbase] != 7 || q_idx[vbase] != 0) begin
        n_bad++;
        $display("[TB] FAIL midhigh_report: got per=%0d hi=%0d idx=%0d want per=20 hi=7 idx=0",
                 q_per[vbase], q_hi[vbase], q_idx[vbase]);
      end
    end
  endtask

  task automatic test_timeout();
    int vbase, tbase, k, cnt;
    // Level held low from the start of the run
    gen_on   = 1'b0;
    hold_lvl = 1'b0;
    repeat (10) tick();
    vbase = q_per.size();
    tbase = n_to;
    i_times = 16'd2;
    i_en    = 1'b1;
    k = 0;
    while (o_busy !== 1'b1 && k < 10) begin tick(); k++; end
    i_en = 1'b0;
    cnt = 0;
    while (o_timeout !== 1'b1 && cnt < 200) begin tick(); cnt++; end
    n_cmp++;
    if (cnt != TO_CYC) begin n_bad++; $display("[TB] FAIL timeout_low_cycles: got %0d want %0d", cnt, TO_CYC); end
    tick();
    n_cmp++;
    if (o_timeout !== 1'b0 || o_busy !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL timeout_low_after: got timeout=%b busy=%b want 0 0", o_timeout, o_busy);
    end
    // Level rises once during the run and then stays high
    i_en = 1'b1;
    k = 0;
    while (o_busy !== 1'b1 && k < 10) begin tick(); k++; end
    i_en = 1'b0;
    repeat (20) tick();
    hold_lvl = 1'b1;
    k = 0;
    while (i_pwm !== 1'b1 && k < 5) begin tick(); k++; end
    cnt = 0;
    while (o_timeout !== 1'b1 && cnt < 200) begin tick(); cnt++; end
    n_cmp++;
    if (cnt != TO_CYC + 4 + LAT_EXTRA) begin
      n_bad++;
      $display("[TB] FAIL timeout_high_cycles: got %0d want %0d", cnt, TO_CYC + 4 + LAT_EXTRA);
    end
    tick();
    n_cmp++;
    if (q_per.size() != vbase || n_to != tbase + 2) begin
      n_bad++;
      $display("[TB] FAIL timeout_strobes: got valids=%0d timeouts=%0d want 0 2", q_per.size() - vbase, n_to - tbase);
    end
    hold_lvl = 1'b0;
  endtask

  task automatic test_reset_mid();
    int vbase, dbase, k;
    set_pwm(10, 3, 0, 0);
    repeat (5) tick();
    vbase = q_per.size();
    dbase = n_done;
    start_run(5);
    k = 0;
    while (q_per.size() == vbase && k < 100) begin tick(); k++; end
    n_cmp++;
    if (q_per.size() != vbase + 1 || q_idx[vbase] != 0) begin
      n_bad++;
      $display("[TB] FAIL rstmid_first: got %0d reports want 1 with idx 0", q_per.size() - vbase);
    end
    i_rst = 1'b1;
    tick();
    n_cmp++;
    if ({o_valid, o_done, o_timeout, o_busy} !== 4'b0000 || o_period !== '0 || o_high !== '0 || o_idx !== '0) begin
      n_bad++;
      $display("[TB] FAIL rstmid_outputs: got v=%b d=%b t=%b b=%b per=%0d hi=%0d idx=%0d want all 0",
               o_valid, o_done, o_timeout, o_busy, o_period, o_high, o_idx);
    end
    i_rst = 1'b0;
    repeat (40) tick();
    n_cmp++;
    if (q_per.size() != vbase + 1 || n_done != dbase) begin
      n_bad++;
      $display("[TB] FAIL rstmid_quiet: got valids=%0d dones=%0d want 1 0", q_per.size() - vbase, n_done - dbase);
    end
    vbase = q_per.size();
    start_run(2);
    wait_done(dbase, 200, "rstmid");
    n_cmp++;
    if (q_per.size() != vbase + 2) begin
      n_bad++;
      $display("[TB] FAIL rstmid_restart_count: got %0d want 2", q_per.size() - vbase);
    end else begin
      n_cmp++;
      if (q_idx[vbase] != 0 || q_idx[vbase+1] != 1 || q_per[vbase] != 10 || q_hi[vbase] != 3) begin
        n_bad++;
        $display("[TB] FAIL rstmid_restart: got idx=%0d,%0d per=%0d hi=%0d want idx=0,1 per=10 hi=3",
                 q_idx[vbase], q_idx[vbase+1], q_per[vbase], q_hi[vbase]);
      end
    end
  endtask

  task automatic test_glitch();
    int vbase, dbase, nshort;
    bit ok;
    set_pwm(40, 15, 25, 2);
    repeat (5) tick();
    vbase = q_per.size();
    dbase = n_done;
    start_run(4);
    wait_done(dbase, 400, "glitch");
    n_cmp++;
    if (q_per.size() != vbase + 4) begin
      n_bad++;
      $display("[TB] FAIL glitch_count: got %0d want 4", q_per.size() - vbase);
    end else begin
      nshort = 0;
      for (int i = 0; i < 4; i++) begin
        if (DGL_BUILD) ok = (q_per[vbase+i] == 40 && q_hi[vbase+i] == 15);
        else ok = (q_per[vbase+i] == 25 && q_hi[vbase+i] == 15) || (q_per[vbase+i] == 15 && q_hi[vbase+i] == 2);
        if (q_per[vbase+i] == 15) nshort++;
        n_cmp++;
        if (!ok) begin
          n_bad++;
          $display("[TB] FAIL glitch_report%0d: got per=%0d hi=%0d (deglitch=%0b)", i, q_per[vbase+i], q_hi[vbase+i], DGL_BUILD);
        end
      end
      n_cmp++;
      if (nshort != (DGL_BUILD ? 0 : 2)) begin
        n_bad++;
        $display("[TB] FAIL glitch_short_periods: got %0d want %0d", nshort, DGL_BUILD ? 0 : 2);
      end
    end
  endtask

  task automatic test_times0();
    int vbase, dbase;
    set_pwm(10, 3, 0, 0);
    repeat (5) tick();
    vbase = q_per.size();
    dbase = n_done;
    start_run(0);
    i_times = 16'd7;
    repeat (3) tick();
    n_cmp++;
    if (o_busy !== 1'b1) begin n_bad++; $display("[TB] FAIL times0_busy: got %b want 1", o_busy); end
    i_en = 1'b1;
    tick();
    tick();
    i_en = 1'b0;
    wait_done(dbase, 200, "times0");
    repeat (60) tick();
    n_cmp++;
    if (q_per.size() != vbase + 1 || n_done != dbase + 1) begin
      n_bad++;
      $display("[TB] FAIL times0_count: got valids=%0d dones=%0d want 1 1", q_per.size() - vbase, n_done - dbase);
    end else begin
      n_cmp++;
      if (q_per[vbase] != 10 || q_hi[vbase] != 3 || q_idx[vbase] != 0 || done_vld !== 1'b1) begin
        n_bad++;
        $display("[TB] FAIL times0_report: got per=%0d hi=%0d idx=%0d dvalid=%b want 10 3 0 1",
                 q_per[vbase], q_hi[vbase], q_idx[vbase], done_vld);
      end
    end
    n_cmp++;
    if (o_busy !== 1'b0) begin n_bad++; $display("[TB] FAIL times0_idle: got busy=%b want 0", o_busy); end
  endtask

  // Scenarios run back to back on one DUT instance
  initial begin : main
    $display("[TB] pwm_capture bench start (deglitch=%0b)", DGL_BUILD);
    test_reset();
    test_basic();
    test_midhigh();
    test_timeout();
    test_reset_mid();
    test_glitch();
    test_times0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
